// File: rtl/spi_slave_port.sv
// SPI mode-0 target port: oversamples the master's spi_clk/cs_n/mosi on the local clock,
// shifts W_DATA-bit words MSB first and offers a one-deep transmit holding register.
module spi_slave_port #(
  parameter int W_DATA      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [W_DATA-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_DATA-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CW = $clog2(W_DATA);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  logic [W_DATA-1:0]      tx_shift_q, tx_shift_d;
  logic [W_DATA-1:0]      rx_shift_q, rx_shift_d;
  logic [W_DATA-1:0]      rx_data_q, rx_data_d;
  logic [W_DATA-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   word_done_q, word_done_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic consume;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
  end

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        consume     = ~cs_rise;
        bit_cnt_d   = '0;
        word_done_d = 1'b0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[W_DATA-2:0], mosi_s};
          if (bit_cnt_q == CW'(W_DATA-1)) begin
            rx_data_d   = rx_shift_d;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (sclk_fall) begin
          if (word_done_q) begin
            consume     = ~cs_rise;
            word_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[W_DATA-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty holding register at a word start sends zeros and flags the underrun
    if (consume) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Frame end discards any partial word but keeps a coincident completed word
    if (cs_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      word_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso        = (state_q == SHIFT) & tx_shift_q[W_DATA-1];
  assign busy        = (state_q != IDLE);
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: plays an SPI master bit by bit and checks against a word-level
// model of the holding register, transmitted words, received words and underrun pulses.
module tb_spi_slave_port;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_clk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [31:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        tx_underrun;
   logic        busy;

   int vectors = 0;
   int errors = 0;

   // Word-level model: holding register, underrun count and the last received word
   logic [31:0] m_hold = '0;
   bit          m_full = 1'b0;
   int          m_underruns = 0;
   logic [31:0] m_last_rx = '0;

   logic [31:0] mosi_words[$];
   logic [31:0] refill_q[$];
   logic [31:0] exp_miso[$];
   logic [31:0] got_miso[$];
   logic [31:0] rx_seen[$];
   int          underrun_seen = 0;

   spi_slave_port #(.W_DATA(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Collect receive strobes and underrun pulses away from the active edge
   always @(negedge clk) begin
      if (rx_valid) rx_seen.push_back(rx_data);
      if (tx_underrun) underrun_seen++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_consume(output logic [31:0] w);
      if (m_full) begin
         w = m_hold;
         m_full = 1'b0;
      end else begin
         w = '0;
         m_underruns++;
      end
   endtask

   task automatic offer(input logic [31:0] word);
      tx_data = word;
      tx_valid = 1'b1;
      if (!m_full) begin
         m_hold = word;
         m_full = 1'b1;
      end
      wait_clks(1);
      tx_valid = 1'b0;
   endtask

   // One chip-select frame of nbits; every word start, including the reload after the
   // final word's falling edge, takes the holding register in the model
   task automatic run_frame(input int nbits);
      logic [31:0] cap;
      logic [31:0] word;
      exp_miso.delete();
      got_miso.delete();
      cap = '0;
      spi_clk = 1'b0;
      cs_n = 1'b0;
      wait_clks(8);
      model_consume(word);
      exp_miso.push_back(word);
      for (int b = 0; b < nbits; b++) begin
         int i;
         int w;
         i = b % 32;
         w = b / 32;
         if (i == 0 && b > 0) begin
            model_consume(word);
            exp_miso.push_back(word);
         end
         mosi = mosi_words[w][31-i];
         wait_clks(HALF);
         cap[31-i] = miso;
         spi_clk = 1'b1;
         if (i == 10 && refill_q.size() > 0) offer(refill_q.pop_front());
         wait_clks(HALF);
         spi_clk = 1'b0;
         if (i == 31) got_miso.push_back(cap);
      end
      if (nbits > 0 && nbits % 32 == 0) begin
         model_consume(word);
         m_last_rx = mosi_words[nbits/32-1];
      end
      wait_clks(HALF);
      cs_n = 1'b1;
      wait_clks(8);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clks(3);
      vectors++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso got %b want 0", miso); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready got %b want 1", tx_ready); end
      vectors++; if (rx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rx_data got %h want 0", rx_data); end
      vectors++; if ({rx_valid, tx_underrun, busy} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_pulses got %b want 000", {rx_valid, tx_underrun, busy});
      end
      rst = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_single_word();
      int u0, mu0, r0;
      offer(32'h12345678);
      vectors++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_loaded got %b want 0", tx_ready); end
      mosi_words = '{32'hA5A5F00F};
      u0 = underrun_seen; mu0 = m_underruns; r0 = rx_seen.size();
      run_frame(32);
      vectors++; if (got_miso[0] !== exp_miso[0]) begin errors++; $display("[TB] FAIL single_miso got %h want %h", got_miso[0], exp_miso[0]); end
      vectors++; if (rx_seen.size() != r0 + 1) begin errors++; $display("[TB] FAIL single_rx_count got %0d want %0d", rx_seen.size() - r0, 1); end
      else begin
         vectors++; if (rx_seen[r0] !== 32'hA5A5F00F) begin errors++; $display("[TB] FAIL single_rx_word got %h want a5a5f00f", rx_seen[r0]); end
      end
      vectors++; if (rx_data !== 32'hA5A5F00F) begin errors++; $display("[TB] FAIL single_rx_data got %h want a5a5f00f", rx_data); end
      vectors++; if (underrun_seen - u0 != m_underruns - mu0) begin
         errors++; $display("[TB] FAIL single_underruns got %0d want %0d", underrun_seen - u0, m_underruns - mu0);
      end
      vectors++; if (tx_ready !== !m_full) begin errors++; $display("[TB] FAIL single_ready_after got %b want %b", tx_ready, !m_full); end
   endtask

   task automatic test_back_to_back();
      int r0;
      offer(32'h11111111);
      refill_q = '{32'h22222222};
      mosi_words = '{32'hDEADBEEF, 32'hCAFEF00D};
      r0 = rx_seen.size();
      run_frame(64);
      for (int k = 0; k < 2; k++) begin
         vectors++; if (got_miso[k] !== exp_miso[k]) begin errors++; $display("[TB] FAIL b2b_miso%0d got %h want %h", k, got_miso[k], exp_miso[k]); end
      end
      vectors++; if (rx_seen.size() != r0 + 2) begin errors++; $display("[TB] FAIL b2b_rx_count got %0d want 2", rx_seen.size() - r0); end
      else begin
         for (int k = 0; k < 2; k++) begin
            vectors++; if (rx_seen[r0+k] !== mosi_words[k]) begin errors++; $display("[TB] FAIL b2b_rx%0d got %h want %h", k, rx_seen[r0+k], mosi_words[k]); end
         end
      end
   endtask

   task automatic test_underrun();
      int u0, mu0, r0;
      mosi_words = '{$urandom};
      u0 = underrun_seen; mu0 = m_underruns; r0 = rx_seen.size();
      run_frame(32);
      vectors++; if (got_miso[0] !== 32'h0) begin errors++; $display("[TB] FAIL underrun_miso got %h want 0", got_miso[0]); end
      vectors++; if (underrun_seen - u0 != m_underruns - mu0) begin
         errors++; $display("[TB] FAIL underrun_count got %0d want %0d", underrun_seen - u0, m_underruns - mu0);
      end
      vectors++; if (rx_seen.size() != r0 + 1 || rx_data !== mosi_words[0]) begin
         errors++; $display("[TB] FAIL underrun_rx got %h want %h", rx_data, mosi_words[0]);
      end
   endtask

   task automatic test_partial_frame();
      int r0;
      mosi_words = '{$urandom};
      r0 = rx_seen.size();
      run_frame(10);
      vectors++; if (rx_seen.size() != r0) begin errors++; $display("[TB] FAIL partial_rx_count got %0d want 0", rx_seen.size() - r0); end
      vectors++; if (rx_data !== m_last_rx) begin errors++; $display("[TB] FAIL partial_rx_hold got %h want %h", rx_data, m_last_rx); end
      mosi_words = '{$urandom};
      run_frame(32);
      vectors++; if (rx_seen.size() != r0 + 1 || rx_data !== mosi_words[0]) begin
         errors++; $display("[TB] FAIL partial_next_rx got %h want %h", rx_data, mosi_words[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] word;
      offer(32'h5A5A1234);
      mosi_words = '{32'hFFFF0000};
      cs_n = 1'b0;
      wait_clks(8);
      model_consume(word);
      for (int b = 0; b < 17; b++) begin
         mosi = mosi_words[0][31-b];
         wait_clks(HALF);
         spi_clk = 1'b1;
         wait_clks(HALF);
         spi_clk = 1'b0;
      end
      #2 rst = 1'b1;
      m_full = 1'b0;
      m_last_rx = '0;
      #1;
      vectors++; if ({miso, tx_ready, rx_valid, tx_underrun, busy} !== 5'b01000) begin
         errors++; $display("[TB] FAIL midreset_outputs got %b want 01000", {miso, tx_ready, rx_valid, tx_underrun, busy});
      end
      vectors++; if (rx_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rx_data got %h want 0", rx_data); end
      wait_clks(2);
      rst = 1'b0;
      wait_clks(10);
      vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_fall_busy got %b want 0", busy); end
      cs_n = 1'b1;
      wait_clks(8);
      mosi_words = '{32'h0000FFFF};
      run_frame(32);
      vectors++; if (rx_data !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL midreset_next_rx got %h want 0000ffff", rx_data); end
   endtask

   task automatic test_ignore_when_full();
      offer(32'hAAAA5555);
      offer(32'h99999999);
      vectors++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL ignore_ready got %b want 0", tx_ready); end
      mosi_words = '{$urandom};
      run_frame(32);
      vectors++; if (got_miso[0] !== 32'hAAAA5555) begin errors++; $display("[TB] FAIL ignore_miso got %h want aaaa5555", got_miso[0]); end
      vectors++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore_ready_after got %b want 1", tx_ready); end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 5; f++) begin
         int n, u0, mu0, r0;
         n = $urandom_range(1, 3);
         mosi_words.delete();
         refill_q.delete();
         for (int k = 0; k < n; k++) mosi_words.push_back($urandom);
         if ($urandom_range(0, 1) == 1) offer($urandom);
         for (int k = 0; k < n; k++) if ($urandom_range(0, 1) == 1) refill_q.push_back($urandom);
         u0 = underrun_seen; mu0 = m_underruns; r0 = rx_seen.size();
         run_frame(32 * n);
         for (int k = 0; k < n; k++) begin
            vectors++; if (got_miso[k] !== exp_miso[k]) begin errors++; $display("[TB] FAIL rand%0d_miso%0d got %h want %h", f, k, got_miso[k], exp_miso[k]); end
         end
         vectors++; if (rx_seen.size() != r0 + n) begin errors++; $display("[TB] FAIL rand%0d_rx_count got %0d want %0d", f, rx_seen.size() - r0, n); end
         else begin
            for (int k = 0; k < n; k++) begin
               vectors++; if (rx_seen[r0+k] !== mosi_words[k]) begin errors++; $display("[TB] FAIL rand%0d_rx%0d got %h want %h", f, k, rx_seen[r0+k], mosi_words[k]); end
            end
         end
         vectors++; if (underrun_seen - u0 != m_underruns - mu0) begin
            errors++; $display("[TB] FAIL rand%0d_underruns got %0d want %0d", f, underrun_seen - u0, m_underruns - mu0);
         end
         vectors++; if (tx_ready !== !m_full) begin errors++; $display("[TB] FAIL rand%0d_ready got %b want %b", f, tx_ready, !m_full); end
      end
   endtask

   // Scenarios run in order; each leaves the port idle with cs_n high
   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_partial_frame();
      test_reset_mid_frame();
      test_ignore_when_full();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (target) end of the CPU SPI link: the far-side device that answers the CPU's SPI master.
- Runs on its own system clock; spi_clk, cs_n and mosi are oversampled asynchronously.
- Mode 0 (CPOL=0, CPHA=0), MSB first, W_DATA-bit words; multiple words per chip-select frame allowed.
- Provides a one-deep transmit holding register and a received-word strobe to local logic.

Parameters:
W_DATA, 32, word width in bits (matches `W_CPU)
SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (min 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
spi_clk  input  1  SPI serial clock from master (async)
cs_n  input  1  active-low chip select from master (async)
mosi  input  1  serial data from master (async)
miso  output  1  serial data to master
tx_data  input  W_DATA  word to return on next transfer
tx_valid  input  1  tx_data offered; accepted when tx_ready=1
tx_ready  output  1  holding register empty
rx_data  output  W_DATA  last complete word received
rx_valid  output  1  one-cycle pulse: rx_data updated
tx_underrun  output  1  one-cycle pulse: word began with empty holding register
busy  output  1  frame in progress (synchronized cs_n low)

Behaviour:
- Reset (async, any time):
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
  - Shift registers, bit counter, holding register and sync chains cleared.
  - FSM returns to IDLE; reception resumes only after a fresh cs_n falling edge.
- Sync and edge detection:
  - spi_clk, cs_n and mosi each pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected by comparing the last sync stage with the history flop.
  - Each spi_clk half-period must be at least SYNC_STAGES+2 clk periods; faster spi_clk is unsupported.
- Holding register:
  - tx_valid & tx_ready loads tx_data and drops tx_ready on the next clk.
  - tx_valid is ignored while tx_ready=0.
  - tx_ready rises the clk after the holding word moves to the tx shift register.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: busy=0, miso=0. A synchronized cs_n fall goes to LOAD.
  - LOAD (one cycle): tx_shift <= holding word if full, else 0 with tx_underrun pulsed. bit_cnt=0. Next state SHIFT. busy=1.
  - SHIFT:
    - miso = tx_shift[W_DATA-1] combinationally.
    - Synchronized spi_clk rise: rx_shift <= {rx_shift[W_DATA-2:0], mosi_sync}; bit_cnt++.
    - When bit_cnt becomes W_DATA: rx_data <= assembled word, rx_valid pulses the same clk, bit_cnt <= 0, word_done set.
    - Synchronized spi_clk fall with word_done clear: tx_shift <<= 1, LSB filled with 0.
    - Synchronized spi_clk fall with word_done set: reload tx_shift from the holding register (same underrun rule as LOAD) and clear word_done. This gives back-to-back words in one frame.
  - Synchronized cs_n rise in any state goes to IDLE.
    - Partial word is discarded: no rx_valid, bit_cnt cleared, rx_data unchanged.
    - A completed word's rx_valid is still issued if it coincides with the cs_n rise.
- Latency: rx_valid is asserted on the clk edge where the last rising spi_clk edge is detected, i.e. SYNC_STAGES+1 clk edges after spi_clk is first sampled high.
- Simultaneous events:
  - tx_valid accepted on the same clk as a LOAD/reload: the reload takes the old holding contents; the new word refills the holding register.
  - If the holding register is empty at reload, the new word is held for the next word.
- rx_data holds its value until the next complete word; there is no overrun detection, so the consumer must take it on rx_valid.

Test Plan:
- Preload tx 0x12345678. Frame of 32 clocks with MOSI=0xA5A5F00F. Expect: miso bit stream 0x12345678 MSB first; rx_valid one pulse; rx_data=0xA5A5F00F; tx_ready high after LOAD.
- Back-to-back: holding 0x11111111, refill 0x22222222 mid-word. 64-bit frame with MOSI 0xDEADBEEF then 0xCAFEF00D. Expect: two rx_valid pulses with those values; miso returns 0x11111111 then 0x22222222.
- Empty holding at cs_n fall. Expect: tx_underrun pulse; miso all zero; rx still correct.
- cs_n deasserted after 10 bits. Expect: no rx_valid; rx_data keeps its previous value. Next full frame receives correctly from bit 0.
- rst asserted at bit 17. Expect: all outputs return to reset values immediately. Next frame with 0x0000FFFF is received correctly.
- tx_valid with 0x99999999 while tx_ready=0. Expect: ignored; miso returns the earlier holding word.
